// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage.
// IF_MISALIGN_CHECK_EN adds a misalign flag to the downstream entry.
package if_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
`ifdef IF_MISALIGN_CHECK_EN
        logic        misalign;
`endif
    } if_stage_out_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for the fetched-word
// queue and the in-flight request-PC queue. DEPTH must be a power of two.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    // Storage is not reset; entries only become visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, fetch buffer, redirect flush.
// Optional misaligned-redirect trap entry when IF_MISALIGN_CHECK_EN is defined.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic          clk,
    input  logic          arst_n,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [31:0]   imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    input  logic          redirect_en,
    input  logic [31:0]   redirect_pc,
    output if_stage_out_t if_out,
    output logic          if_valid,
    input  logic          if_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] OUT_ONE = OW'(1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTST);
    localparam logic [31:0]   DEPTH_U = 32'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d, tgt_pc, rsp_pc;
    logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
    logic          run_q, halt, nop_push;
    logic          req_fire, data_push, data_pop, data_empty;
    logic [CW-1:0] data_cnt;
    if_stage_out_t push_ent, head_ent;
    logic [CW-1:0] unused_pc_cnt;
    logic          unused_pc_empty, unused_pc_full, unused_data_full;

`ifdef IF_MISALIGN_CHECK_EN
    logic nop_pend_q;

    assign tgt_pc   = redirect_pc;
    // Trap entry waits until every stale response has been drained.
    assign nop_push = nop_pend_q && (outst_q == '0) && !redirect_en;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            halt       <= 1'b0;
            nop_pend_q <= 1'b0;
        end else if (redirect_en) begin
            halt       <= |redirect_pc[1:0];
            nop_pend_q <= |redirect_pc[1:0];
        end else if (nop_push) begin
            nop_pend_q <= 1'b0;
        end
    end

    always_comb begin
        push_ent = '0;
        if (nop_push) begin
            push_ent.pc       = pc_q;
            push_ent.inst     = NOP_INST;
            push_ent.misalign = 1'b1;
        end else begin
            push_ent.pc   = rsp_pc;
            push_ent.inst = imem_rsp_data;
        end
    end
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign tgt_pc   = {redirect_pc[31:2], 2'b00};
    assign halt     = 1'b0;
    assign nop_push = 1'b0;

    always_comb begin
        push_ent      = '0;
        push_ent.pc   = rsp_pc;
        push_ent.inst = imem_rsp_data;
    end
`endif

    // Credit covers buffered words plus in-flight requests, so responses never stall.
    assign imem_req_valid = run_q && !redirect_en && !halt
                            && ((32'(outst_q) + 32'(data_cnt)) < DEPTH_U)
                            && (outst_q < OUT_MAX);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign data_push      = (imem_rsp_valid && (discard_q == '0) && !redirect_en) || nop_push;
    assign data_pop       = if_valid && if_ready && !redirect_en;

    always_comb begin
        outst_d = outst_q;
        if (req_fire && !imem_rsp_valid)      outst_d = outst_q + OUT_ONE;
        else if (!req_fire && imem_rsp_valid) outst_d = outst_q - OUT_ONE;

        discard_d = discard_q;
        if (redirect_en)                                discard_d = outst_d;
        else if (imem_rsp_valid && (discard_q != '0))   discard_d = discard_q - OUT_ONE;

        pc_d = pc_q;
        if (redirect_en)   pc_d = tgt_pc;
        else if (req_fire) pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            run_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            run_q     <= 1'b1;
        end
    end

    // Request-PC queue stays aligned with responses across redirects, so it is never flushed.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_fifo (
        .clk   (clk),
        .arst_n(arst_n),
        .push  (req_fire),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .din   (pc_q),
        .dout  (rsp_pc),
        .count (unused_pc_cnt),
        .empty (unused_pc_empty),
        .full  (unused_pc_full)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(if_stage_out_t))) u_data_fifo (
        .clk   (clk),
        .arst_n(arst_n),
        .push  (data_push),
        .pop   (data_pop),
        .flush (redirect_en),
        .din   (push_ent),
        .dout  (head_ent),
        .count (data_cnt),
        .empty (data_empty),
        .full  (unused_data_full)
    );

    assign if_valid = !data_empty;
    assign if_out   = if_valid ? head_ent : '0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural in-order instruction memory.
// The misaligned-redirect step runs only when IF_MISALIGN_CHECK_EN is defined.
module tb_if_stage;
    import if_stage_pkg::*;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          req_ready = 1'b0;
    logic          rsp_valid = 1'b0;
    logic [31:0]   rsp_data = 32'h0;
    logic          redirect_en = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          if_ready = 1'b0;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          if_valid;
    if_stage_out_t if_out;

    if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTST(2)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .imem_req_valid(req_valid),
        .imem_req_ready(req_ready),
        .imem_req_addr (req_addr),
        .imem_rsp_valid(rsp_valid),
        .imem_rsp_data (rsp_data),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .if_out        (if_out),
        .if_valid      (if_valid),
        .if_ready      (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          n_pop = 0;
    int          n_fire = 0;
    int          mark = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] last_pop_pc = 32'hFFFF_FFFF;
    bit          sb_en = 1'b1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1357_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present due response, observe handshakes, advance to next negedge.
    task automatic tick();
        req_t r;
        if (q.size() > 0 && q[0].due == cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = memf(q[0].addr);
            void'(q.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #1;
        if (redirect_en) chk("req_in_redirect", 64'(req_valid), 64'(0));
        if (req_valid && req_ready) begin
            chk("req_addr", 64'(req_addr), 64'(exp_addr));
            exp_addr += 32'd4;
            n_fire++;
            r.addr   = req_addr;
            r.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = r.due;
            q.push_back(r);
        end
        if (if_valid && if_ready && !redirect_en) begin
            n_pop++;
            last_pop_pc = if_out.pc;
            if (sb_en) begin
                chk("pop_pc", 64'(if_out.pc), 64'(exp_pc));
                chk("pop_inst", 64'(if_out.inst), 64'(memf(exp_pc)));
                exp_pc += 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_if_valid", 64'(if_valid), 64'(0));
        chk("rst_if_pc", 64'(if_out.pc), 64'(0));
        chk("rst_if_inst", 64'(if_out.inst), 64'(0));
        @(negedge clk);

        // Streaming fetch with 1-cycle memory
        req_ready = 1'b1;
        if_ready  = 1'b1;
        lat       = 1;
        arst_n    = 1'b1;
        tick();
        #1;
        chk("first_req_valid", 64'(req_valid), 64'(1));
        chk("first_req_addr", 64'(req_addr), 64'(32'h0));
        tick();
        #1;
        chk("lat_no_valid_at_rsp", 64'(if_valid), 64'(0));
        tick();
        #1;
        chk("lat_valid_after_rsp", 64'(if_valid), 64'(1));
        chk("lat_first_pc", 64'(if_out.pc), 64'(32'h0));
        repeat (12) tick();

        // Downstream stall fills the buffer and stops requests
        if_ready = 1'b0;
        repeat (10) tick();
        #1;
        chk("stall_req_valid", 64'(req_valid), 64'(0));
        chk("stall_if_valid", 64'(if_valid), 64'(1));
        chk("stall_head_pc", 64'(if_out.pc), 64'(exp_pc));
        if_ready = 1'b1;
        mark = n_pop;
        repeat (10) tick();
        chk("stall_release_pops", 64'(n_pop > mark + 2), 64'(1));

        // Redirect with two requests in flight on a 3-cycle memory
        lat = 3;
        for (int i = 0; i < 20 && q.size() != 2; i++) tick();
        chk("redir_two_outst", 64'(q.size()), 64'(2));
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_en = 1'b0;
        exp_pc      = 32'h0000_0100;
        exp_addr    = 32'h0000_0100;
        #1;
        chk("redir_flushed", 64'(if_valid), 64'(0));
        mark = n_pop;
        for (int i = 0; i < 40 && n_pop == mark; i++) tick();
        chk("redir_first_pc", 64'(last_pop_pc), 64'(32'h100));

        // Random back-pressure on both sides
        mark = n_pop;
        for (int i = 0; i < 200; i++) begin
            req_ready = 1'($urandom_range(0, 1));
            if_ready  = 1'($urandom_range(0, 1));
            lat       = int'($urandom_range(1, 3));
            tick();
        end
        req_ready = 1'b1;
        if_ready  = 1'b1;
        lat       = 1;
        repeat (10) tick();
        chk("rand_progress", 64'(n_pop > mark + 20), 64'(1));

        // Asynchronous reset in the middle of a burst
        repeat (3) tick();
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 64'(req_valid), 64'(0));
        chk("mid_rst_if_valid", 64'(if_valid), 64'(0));
        chk("mid_rst_if_pc", 64'(if_out.pc), 64'(0));
        chk("mid_rst_if_inst", 64'(if_out.inst), 64'(0));
        q.delete();
        rsp_valid = 1'b0;
        @(negedge clk);
        tick();
        arst_n   = 1'b1;
        exp_pc   = 32'h0;
        exp_addr = 32'h0;
        mark     = n_pop;
        for (int i = 0; i < 20 && n_pop == mark; i++) tick();
        chk("restart_pc", 64'(last_pop_pc), 64'(32'h0));
        repeat (6) tick();

`ifdef IF_MISALIGN_CHECK_EN
        // Misaligned redirect produces a single trap entry and halts fetch
        sb_en       = 1'b0;
        if_ready    = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect_en = 1'b0;
        mark        = n_fire;
        for (int i = 0; i < 20 && !if_valid; i++) tick();
        #1;
        chk("mis_valid", 64'(if_valid), 64'(1));
        chk("mis_pc", 64'(if_out.pc), 64'(32'h102));
        chk("mis_inst", 64'(if_out.inst), 64'(32'h0000_0013));
        chk("mis_flag", 64'(if_out.misalign), 64'(1));
        repeat (5) tick();
        chk("mis_no_req", 64'(n_fire), 64'(mark));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
